// File: rtl/sound_mixer_pkg.sv
// Shared types and helpers for the sample-playback mixer: channel state,
// sign-magnitude decode and output range constants.
package sound_mixer_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StPlay
    } ch_state_e;

    // Widest sample the decode helper accepts.
    localparam int unsigned SmMaxW = 16;

    // Sign-magnitude to two's complement; negative zero decodes to 0.
    function automatic logic signed [SmMaxW-1:0] sm_decode(input logic [SmMaxW-1:0] raw,
                                                           input int unsigned width);
        logic [SmMaxW-1:0] mag;
        logic              sign;
        mag  = raw & ((SmMaxW'(1) << (width - 1)) - SmMaxW'(1));
        sign = ((raw >> (width - 1)) & SmMaxW'(1)) != '0;
        return sign ? -$signed(mag) : $signed(mag);
    endfunction

    function automatic int midscale(input int unsigned out_w);
        return 1 << (out_w - 1);
    endfunction

    function automatic int out_max(input int unsigned out_w);
        return (1 << out_w) - 1;
    endfunction

endpackage

// File: rtl/sound_channel.sv
// One playback channel: pending trig/stop capture, IDLE/PLAY state and the
// registered ROM address, all advanced on the sample tick.
module sound_channel
    import sound_mixer_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              trig,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              busy
);

    ch_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] play_len_q, play_len_d;
    logic [ADDR_W-1:0] pend_len_q, pend_len_d;
    logic              trig_pend_q, trig_pend_d;
    logic              stop_pend_q, stop_pend_d;

    // A request on the tick cycle itself counts as already pending.
    logic              trig_now, stop_now;
    logic [ADDR_W-1:0] trig_len;

    assign trig_now = trig | trig_pend_q;
    assign stop_now = stop | stop_pend_q;
    assign trig_len = trig ? len : pend_len_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            play_len_q  <= '0;
            pend_len_q  <= '0;
            trig_pend_q <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            play_len_q  <= play_len_d;
            pend_len_q  <= pend_len_d;
            trig_pend_q <= trig_pend_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        play_len_d  = play_len_q;
        pend_len_d  = trig_len;
        trig_pend_d = trig_now;
        stop_pend_d = stop_now;
        if (tick) begin
            trig_pend_d = 1'b0;
            stop_pend_d = 1'b0;
            if (stop_now) begin
                state_d = StIdle;
                addr_d  = '0;
            end else if (trig_now && trig_len != '0) begin
                state_d    = StPlay;
                addr_d     = '0;
                play_len_d = trig_len;
            end else if (state_q == StPlay) begin
                if (addr_q == play_len_q - 1'b1) begin
                    addr_d = '0;
                    if (!loop) begin
                        state_d = StIdle;
                    end
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        unique case (state_q)
            StIdle:  busy = 1'b0;
            StPlay:  busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign rom_addr = addr_q;

endmodule

// File: rtl/sound_mixer.sv
// Multi-channel sample mixer: tick divider, NUM_CH channels, signed mix with
// gain and saturation. Define SOUND_MIXER_VOLUME_EN to add per-channel volume.
module sound_mixer
    import sound_mixer_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned SAMPLE_W   = 4,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned CLK_DIV    = 3125,
    parameter int unsigned GAIN_SHIFT = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          trig,
    input  logic [NUM_CH-1:0]          stop,
    input  logic [NUM_CH-1:0]          loop,
    input  logic [NUM_CH*ADDR_W-1:0]   len,
    output logic [NUM_CH*ADDR_W-1:0]   rom_addr,
    input  logic [NUM_CH*SAMPLE_W-1:0] rom_data,
`ifdef SOUND_MIXER_VOLUME_EN
    input  logic [NUM_CH*2-1:0]        vol,
`endif
    output logic [NUM_CH-1:0]          busy,
    output logic [OUT_W-1:0]           music_data,
    output logic                       sample_valid
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam int unsigned SumW = SAMPLE_W + $clog2(NUM_CH) + GAIN_SHIFT + 1;
    localparam int unsigned ExtW = SumW + OUT_W + 1;

    localparam logic [OUT_W-1:0]       MidOut = OUT_W'(midscale(OUT_W));
    localparam logic signed [ExtW-1:0] MidExt = ExtW'(midscale(OUT_W));
    localparam logic signed [ExtW-1:0] MaxExt = ExtW'(out_max(OUT_W));

    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    tick;
    logic                    tick_dly_q;
    logic                    valid_q;
    logic [OUT_W-1:0]        music_q;
    logic signed [SumW-1:0]  mix_sum;
    logic signed [ExtW-1:0]  mix_val;
    logic [OUT_W-1:0]        mix_sat;

    assign tick  = (cnt_q == CntW'(CLK_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sound_channel #(
            .ADDR_W (ADDR_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .trig     (trig[i]),
            .stop     (stop[i]),
            .loop     (loop[i]),
            .len      (len[i*ADDR_W +: ADDR_W]),
            .rom_addr (rom_addr[i*ADDR_W +: ADDR_W]),
            .busy     (busy[i])
        );
    end

    // rom_data is read while rom_addr/busy hold the post-tick values.
    always_comb begin
        logic signed [SAMPLE_W-1:0] dec;
        dec     = '0;
        mix_sum = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            dec = SAMPLE_W'(sm_decode(SmMaxW'(rom_data[i*SAMPLE_W +: SAMPLE_W]), SAMPLE_W));
`ifdef SOUND_MIXER_VOLUME_EN
            dec = dec >>> vol[i*2 +: 2];
`endif
            if (busy[i]) begin
                mix_sum = mix_sum + SumW'(dec);
            end
        end
    end

    always_comb begin
        mix_val = (ExtW'(mix_sum) <<< GAIN_SHIFT) + MidExt;
        if (mix_val[ExtW-1]) begin
            mix_sat = '0;
        end else if (mix_val > MaxExt) begin
            mix_sat = '1;
        end else begin
            mix_sat = mix_val[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            tick_dly_q <= 1'b0;
            valid_q    <= 1'b0;
            music_q    <= MidOut;
        end else begin
            cnt_q      <= cnt_d;
            tick_dly_q <= tick;
            valid_q    <= tick_dly_q;
            if (tick_dly_q) begin
                music_q <= mix_sat;
            end
        end
    end

    assign music_data   = music_q;
    assign sample_valid = valid_q;

endmodule
